// File: rtl/ram_2cyc_master.sv
// ram_2cyc_master
// Initiator for a two-cycle synchronous RAM port. A valid/ready request is
// forwarded combinationally to the RAM strobes on accept. Read data arrives
// one cycle later. Every access, including writes, is returned in order
// through a RESP_DEPTH-entry response buffer with valid/ready back-pressure.
// A credit check reserves a buffer slot for every access in flight, so the
// buffer cannot overflow and no read data is lost.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          request handshake
//   req_addr/we/wmask/size/wdata request fields
//   resp_valid/resp_ready        response handshake
//   resp_rdata/resp_is_write     head-of-buffer response (rdata 0 for writes)
//   ram_en/re/we/addr/wmask/size/wdata  RAM strobes (all 0 without an accept)
//   ram_rdata                    RAM read data, valid the cycle after a read
//
// Optional build macro: RAM_MASTER_RALIGN_EN
//   When defined, read data is shifted down by the byte offset of the address
//   and zero-extended above the access size before it enters the buffer.
//   Timing is the same in both builds.
module ram_2cyc_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RESP_DEPTH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_we,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    input  logic [1:0]              req_size,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_is_write,
    output logic                    ram_en,
    output logic                    ram_re,
    output logic                    ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH/8-1:0] ram_wmask,
    output logic [1:0]              ram_size,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    input  logic [DATA_WIDTH-1:0]   ram_rdata
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(RESP_DEPTH);
    localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RESP_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(RESP_DEPTH);

    logic                  accept_s;
    logic                  pop_s;
    logic                  capture_s;
    logic [CNT_W:0]        occ_s;
    logic [DATA_WIDTH-1:0] entry_data_s;

    logic                  inflight_r;
    logic                  is_wr_r;
    logic [CNT_W-1:0]      count_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [DATA_WIDTH-1:0] buf_data_r [RESP_DEPTH];
    logic                  buf_wr_r   [RESP_DEPTH];

`ifdef RAM_MASTER_RALIGN_EN
    // Byte offset and size are only needed to align read data.
    logic [2:0]            addr_lo_r;
    logic [1:0]            size_r;

    function automatic logic [DATA_WIDTH-1:0] align_rdata(
        input logic [DATA_WIDTH-1:0] raw,
        input logic [2:0]            lo,
        input logic [1:0]            size
    );
        logic [DATA_WIDTH-1:0] shifted;
        logic [DATA_WIDTH-1:0] keep;
        int unsigned           lane;
        int unsigned           nbits;
        lane    = 32'(lo) % 32'(STRB_W);
        shifted = raw >> (32'd8 * lane);
        nbits   = 32'd8 << size;
        // Sizes at or above the bus width keep the whole word.
        if (nbits < 32'(DATA_WIDTH)) begin
            keep = ~({DATA_WIDTH{1'b1}} << nbits);
        end else begin
            keep = {DATA_WIDTH{1'b1}};
        end
        return shifted & keep;
    endfunction
`endif

    // Pointer increment wrapping at RESP_DEPTH (not necessarily a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign pop_s     = resp_valid && resp_ready;
    assign capture_s = inflight_r;
    // Occupancy counting the in-flight slot; a same-cycle pop frees a slot.
    // pop_s implies count_r >= 1, so this never underflows.
    assign occ_s     = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r} - {{CNT_W{1'b0}}, pop_s};
    assign req_ready = (occ_s < DEPTH_C);
    assign accept_s  = req_valid && req_ready;

    // RAM strobes: pass-through on accept, all zero otherwise.
    always_comb begin
        ram_en    = 1'b0;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wmask = '0;
        ram_size  = 2'b00;
        ram_wdata = '0;
        if (accept_s) begin
            ram_en    = 1'b1;
            ram_re    = !req_we;
            ram_we    = req_we;
            ram_addr  = req_addr;
            ram_wmask = req_wmask;
            ram_size  = req_size;
            ram_wdata = req_wdata;
        end else begin
            ram_en    = 1'b0;
        end
    end

    // Data written into the buffer for the access completing this cycle.
    always_comb begin
        entry_data_s = '0;
        if (is_wr_r) begin
            entry_data_s = '0;
        end else begin
`ifdef RAM_MASTER_RALIGN_EN
            entry_data_s = align_rdata(ram_rdata, addr_lo_r, size_r);
`else
            entry_data_s = ram_rdata;
`endif
        end
    end

    // In-flight tracker: one access is outstanding for exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_r <= 1'b0;
            is_wr_r    <= 1'b0;
`ifdef RAM_MASTER_RALIGN_EN
            addr_lo_r  <= 3'b000;
            size_r     <= 2'b00;
`endif
        end else begin
            inflight_r <= accept_s;
            if (accept_s) begin
                is_wr_r    <= req_we;
`ifdef RAM_MASTER_RALIGN_EN
                addr_lo_r  <= req_addr[2:0];
                size_r     <= req_size;
`endif
            end
        end
    end

    // Response FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < RESP_DEPTH; i++) begin
                buf_data_r[i] <= '0;
                buf_wr_r[i]   <= 1'b0;
            end
        end else begin
            if (capture_s) begin
                buf_data_r[wr_ptr_r] <= entry_data_s;
                buf_wr_r[wr_ptr_r]   <= is_wr_r;
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({capture_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head-of-buffer response; forced to zero while the buffer is empty.
    always_comb begin
        resp_valid    = (count_r != '0);
        resp_rdata    = '0;
        resp_is_write = 1'b0;
        if (resp_valid) begin
            resp_rdata    = buf_data_r[rd_ptr_r];
            resp_is_write = buf_wr_r[rd_ptr_r];
        end else begin
            resp_rdata    = '0;
            resp_is_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_2cyc_master.sv
module tb_ram_2cyc_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [3:0]  req_wmask;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_is_write;
    logic        ram_en, ram_re, ram_we;
    logic [31:0] ram_addr;
    logic [3:0]  ram_wmask;
    logic [1:0]  ram_size;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    ram_2cyc_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESP_DEPTH(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wmask(req_wmask), .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_is_write(resp_is_write),
        .ram_en(ram_en), .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wmask(ram_wmask), .ram_size(ram_size), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int chk_cnt = 0;
    int pass_cnt = 0;
    int n_acc = 0;

    // Expectation attached to the request currently being driven
    logic [31:0] exp_data;
    logic        exp_wr;
    bit          exp_lat;
    bit          push_en;

    typedef struct {
        logic [31:0] data;
        logic        wr;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    logic        ram_init;
    logic [31:0] mem [256];

    always @(posedge clk) cyc <= cyc + 1;

    // Two-cycle RAM model: sampled at the accept edge, read data held afterwards
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) begin
                if (i == 64)      mem[i] <= 32'hDEADBEEF;
                else if (i == 65) mem[i] <= 32'hCAFEBABE;
                else              mem[i] <= 32'hA000_0000 | 32'(i * 4);
            end
        end else if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wmask[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= mem[ram_addr[9:2]];
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Scoreboard push: record the hand-computed response at each accept
    always @(negedge clk) begin
        if (!rst && req_valid && req_ready) begin
            n_acc++;
            if (push_en) sb_q.push_back('{exp_data, exp_wr, exp_lat ? cyc + 2 : -1});
        end
    end

    // Monitor: compare every consumed response against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (!rst && resp_valid && resp_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_resp", {resp_is_write, resp_rdata}, 33'd0);
            end else begin
                e = sb_q.pop_front();
                check("resp_data", {resp_is_write, resp_rdata}, {e.wr, e.data});
                if (e.cyc >= 0) check("resp_cycle", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] m,
                         input logic [1:0] sz, input logic [31:0] wd,
                         input logic [31:0] ed, input bit push, input bit lat);
        bit got = 1'b0;
        req_valid = 1'b1; req_addr = a; req_we = we; req_wmask = m;
        req_size = sz; req_wdata = wd;
        exp_data = ed; exp_wr = we; push_en = push; exp_lat = lat;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("accept_timeout", {127'd0, got}, 128'd1);
        if (got) begin
            check("ram_strobes", {ram_en, ram_re, ram_we}, {1'b1, !we, we});
            check("ram_fields", {ram_addr, ram_wmask, ram_size, ram_wdata}, {a, m, sz, wd});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int a0;
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0;
        logic [31:0] exp_align;
        rst = 1'b1; ram_init = 1'b1;
        req_valid = 1'b0; req_addr = 32'd0; req_we = 1'b0; req_wmask = 4'd0;
        req_size = 2'd0; req_wdata = 32'd0; resp_ready = 1'b1;
        exp_data = 32'd0; exp_wr = 1'b0; exp_lat = 1'b0; push_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; ram_init = 1'b0;
        req_addr = 32'h55; req_wdata = 32'h77; req_wmask = 4'hF; req_we = 1'b1;

        // Reset state, with request fields non-zero but no valid
        @(negedge clk);
        check("rst_req_ready", {127'd0, req_ready}, 128'd1);
        check("rst_resp", {resp_valid, resp_is_write, resp_rdata}, 34'd0);
        check("rst_ram_strobes", {ram_en, ram_re, ram_we}, 3'b000);
        check("rst_ram_fields", {ram_addr, ram_wmask, ram_size, ram_wdata}, 70'd0);
        @(posedge clk); #1;

        // Single read, write with partial mask, read back merged word
        issue(32'h100, 1'b0, 4'h0, 2'd2, 32'h0, 32'hDEADBEEF, 1'b1, 1'b1);
        issue(32'h104, 1'b1, 4'b0011, 2'd2, 32'h12345678, 32'h0, 1'b1, 1'b1);
        issue(32'h104, 1'b0, 4'h0, 2'd2, 32'h0, 32'hCAFE5678, 1'b1, 1'b1);
        idle(4);

        // Eight back-to-back reads, responses on consecutive cycles
        for (int i = 0; i < 8; i++)
            issue(32'(i * 4), 1'b0, 4'h0, 2'd2, 32'h0, 32'hA000_0000 | 32'(i * 4), 1'b1, 1'b1);
        idle(4);
        check("drain_after_burst", 128'(sb_q.size()), 128'd0);

        // Back-pressure: exactly three accepts, then pop and accept together
        resp_ready = 1'b0;
        req_addr = 32'h0; req_we = 1'b0; req_wmask = 4'h0; req_size = 2'd2; req_wdata = 32'h0;
        exp_data = 32'hA000_0000; exp_wr = 1'b0; exp_lat = 1'b0; push_en = 1'b1;
        a0 = n_acc;
        req_valid = 1'b1;
        repeat (8) @(negedge clk);
        check("bp_accepts", 128'(n_acc - a0), 128'd3);
        check("bp_ready_low", {127'd0, req_ready}, 128'd0);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_pop_and_accept", {req_ready, resp_valid}, 2'b11);
        @(posedge clk); #1;
        req_valid = 1'b0;
        idle(6);
        check("drain_after_bp", 128'(sb_q.size()), 128'd0);

        // Reset in the cycle after an accepted read: response is discarded
        issue(32'h8, 1'b0, 4'h0, 2'd2, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {127'd0, req_ready}, 128'd1);
        check("post_rst_no_resp", {127'd0, resp_valid}, 128'd0);
        idle(4);
        @(negedge clk);
        check("post_rst_still_empty", {127'd0, resp_valid}, 128'd0);
        @(posedge clk); #1;

        // Byte read at 0x103 of word 0xAABBCCDD
`ifdef RAM_MASTER_RALIGN_EN
        exp_align = 32'h0000_00AA;
`else
        exp_align = 32'hAABB_CCDD;
`endif
        issue(32'h100, 1'b1, 4'hF, 2'd2, 32'hAABBCCDD, 32'h0, 1'b1, 1'b1);
        issue(32'h103, 1'b0, 4'h0, 2'd0, 32'h0, exp_align, 1'b1, 1'b1);
        idle(6);
        check("final_drain", 128'(sb_q.size()), 128'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
